// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite frame scheduler.
// Descriptor layout is common to the table and the sequencer.
package sprite_pkg;

  localparam int NUM_SPRITES = 16;
  localparam int SPR_PIXELS  = 256;
  localparam int CORDW       = 10;
  localparam int SPR_IDW     = 4;

  typedef struct packed {
    logic [CORDW-1:0]   x;
    logic [CORDW-1:0]   y;
    logic [7:0]         scale;
    logic [SPR_IDW-1:0] id;
    logic               valid;
  } sprite_desc_t;

  typedef enum logic [2:0] {
    IDLE,
    COMMIT,
    SCAN,
    RUN,
    DONE
  } sched_state_t;

endpackage

// File: rtl/sprite_table.sv
// Double-buffered sprite descriptor table: host writes the shadow,
// commit copies it to the active copy read by the sequencer.
module sprite_table
  import sprite_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int IDXW = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  logic [IDXW-1:0] widx,
  input  sprite_desc_t    wdata,
  input  logic            commit,
  input  logic [IDXW-1:0] ridx,
  output sprite_desc_t    rdata
);

  sprite_desc_t shadow_q [DEPTH];
  sprite_desc_t active_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        shadow_q[i] <= '0;
    end else if (we) begin
      shadow_q[widx] <= wdata;
    end
  end

  // Copy sees the pre-write shadow, so a same-cycle write waits a frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        active_q[i] <= '0;
    end else if (commit) begin
      active_q <= shadow_q;
    end
  end

  assign rdata = active_q[ridx];

endmodule

// File: rtl/sprite_scheduler.sv
// Per-frame sequencer: commits the sprite table and runs the
// single renderer once per drawable entry, in index order.
module sprite_scheduler #(
  parameter int NUM_SPRITES = 16,
  parameter int CORDW       = 10,
  parameter int SPR_IDW     = 4,
  parameter int SPR_PIXELS  = 256,
  localparam int IDXW  = $clog2(NUM_SPRITES),
  localparam int PIXW  = $clog2(SPR_PIXELS),
  localparam int BASEW = SPR_IDW + PIXW
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_start,
  input  logic               cfg_we,
  input  logic [IDXW-1:0]    cfg_idx,
  input  logic [CORDW-1:0]   cfg_x,
  input  logic [CORDW-1:0]   cfg_y,
  input  logic [7:0]         cfg_scale,
  input  logic [SPR_IDW-1:0] cfg_id,
  input  logic               cfg_valid,
  input  logic               rend_finished,
  output logic               rend_rst,
  output logic               rend_enable,
  output logic [CORDW-1:0]   rend_sx,
  output logic [CORDW-1:0]   rend_sy,
  output logic [7:0]         rend_scale,
  output logic [BASEW-1:0]   rend_base,
  output logic [IDXW-1:0]    cur_idx,
  output logic               busy,
  output logic               frame_done,
  output logic               overrun
);

  import sprite_pkg::*;

  sched_state_t state_q, state_d;
  sprite_desc_t wdata, desc;
  logic commit, load, idx_inc, idx_clr;
  logic last, drawable;

  assign wdata = '{
    x:     cfg_x,
    y:     cfg_y,
    scale: cfg_scale,
    id:    cfg_id,
    valid: cfg_valid
  };

  sprite_table #(
    .DEPTH (NUM_SPRITES)
  ) u_table (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (cfg_we),
    .widx   (cfg_idx),
    .wdata  (wdata),
    .commit (commit),
    .ridx   (cur_idx),
    .rdata  (desc)
  );

  assign last     = (cur_idx == IDXW'(NUM_SPRITES - 1));
  assign drawable = desc.valid && (desc.scale != 8'd0);

  always_comb begin
    state_d = state_q;
    commit  = 1'b0;
    load    = 1'b0;
    idx_inc = 1'b0;
    idx_clr = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (frame_start)
          state_d = COMMIT;
      end
      COMMIT: begin
        commit  = 1'b1;
        idx_clr = 1'b1;
        state_d = SCAN;
      end
      SCAN: begin
        if (drawable) begin
          load    = 1'b1;
          state_d = RUN;
        end else if (last) begin
          state_d = DONE;
        end else begin
          idx_inc = 1'b1;
        end
      end
      RUN: begin
        if (rend_finished) begin
          if (last) begin
            state_d = DONE;
          end else begin
            idx_inc = 1'b1;
            state_d = SCAN;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_idx <= '0;
    end else if (idx_clr) begin
      cur_idx <= '0;
    end else if (idx_inc) begin
      cur_idx <= cur_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rend_sx    <= '0;
      rend_sy    <= '0;
      rend_scale <= '0;
      rend_base  <= '0;
    end else if (load) begin
      rend_sx    <= desc.x;
      rend_sy    <= desc.y;
      rend_scale <= desc.scale;
      rend_base  <= BASEW'(desc.id) << PIXW;
    end
  end

  // Status flops follow the next state so they line up with state_q
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rend_rst    <= 1'b1;
      rend_enable <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      rend_rst    <= (state_d != RUN);
      rend_enable <= (state_d == RUN);
      busy        <= (state_d != IDLE);
      frame_done  <= (state_d == DONE);
      overrun     <= frame_start && (state_q != IDLE);
    end
  end

endmodule

// File: tb/tb_sprite_scheduler.sv
// Directed bench for sprite_scheduler with a stub renderer and a
// scoreboard of expected renderer setups.
module tb_sprite_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_start;
  logic        cfg_we;
  logic [3:0]  cfg_idx;
  logic [9:0]  cfg_x, cfg_y;
  logic [7:0]  cfg_scale;
  logic [3:0]  cfg_id;
  logic        cfg_valid;
  logic        rend_finished;
  logic        rend_rst, rend_enable;
  logic [9:0]  rend_sx, rend_sy;
  logic [7:0]  rend_scale;
  logic [11:0] rend_base;
  logic [3:0]  cur_idx;
  logic        busy, frame_done, overrun;

  typedef struct {
    int sx;
    int sy;
    int scale;
    int base;
  } exp_t;

  exp_t sb [$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   lat      = 20;
  int   cnt;
  logic en_prev;

  sprite_scheduler dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .frame_start   (frame_start),
    .cfg_we        (cfg_we),
    .cfg_idx       (cfg_idx),
    .cfg_x         (cfg_x),
    .cfg_y         (cfg_y),
    .cfg_scale     (cfg_scale),
    .cfg_id        (cfg_id),
    .cfg_valid     (cfg_valid),
    .rend_finished (rend_finished),
    .rend_rst      (rend_rst),
    .rend_enable   (rend_enable),
    .rend_sx       (rend_sx),
    .rend_sy       (rend_sy),
    .rend_scale    (rend_scale),
    .rend_base     (rend_base),
    .cur_idx       (cur_idx),
    .busy          (busy),
    .frame_done    (frame_done),
    .overrun       (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Renderer stub: finished pulses lat cycles into a run
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 0;
      rend_finished <= 1'b0;
    end else if (rend_rst) begin
      cnt <= 0;
      rend_finished <= 1'b0;
    end else if (rend_enable) begin
      cnt <= cnt + 1;
      rend_finished <= (cnt == lat - 1);
    end
  end

  // Scoreboard: each renderer start consumes one expected setup
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_prev <= 1'b0;
    end else begin
      en_prev <= rend_enable;
      if (rend_enable && !en_prev) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_run", 32'(cur_idx), 32'hffff);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("sb_sx", 32'(rend_sx), e.sx);
          check("sb_sy", 32'(rend_sy), e.sy);
          check("sb_scale", 32'(rend_scale), e.scale);
          check("sb_base", 32'(rend_base), e.base);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int idx, input int x, input int y,
                           input int sc, input int id, input int v);
    cfg_idx   = 4'(idx);
    cfg_x     = 10'(x);
    cfg_y     = 10'(y);
    cfg_scale = 8'(sc);
    cfg_id    = 4'(id);
    cfg_valid = 1'(v);
    cfg_we    = 1'b1;
    tick();
    cfg_we    = 1'b0;
  endtask

  task automatic push(input int x, input int y, input int sc, input int id);
    exp_t e;
    e.sx = x;
    e.sy = y;
    e.scale = sc;
    e.base = id * 256;
    sb.push_back(e);
  endtask

  task automatic start_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_run();
    int n = 0;
    while (!rend_enable && n < 100) begin
      tick();
      n++;
    end
    check("run_seen", 32'(rend_enable), 1);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!frame_done && n < 200) begin
      tick();
      n++;
    end
    check("done_seen", 32'(frame_done), 1);
  endtask

  task automatic empty_pass(input string tag);
    for (int k = 2; k <= 18; k++) begin
      tick();
      check({tag, "_busy"}, 32'(busy), 1);
      check({tag, "_en"}, 32'(rend_enable), 0);
      check({tag, "_done"}, 32'(frame_done), 32'(k == 18));
    end
    tick();
    check({tag, "_idle"}, 32'(busy), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    frame_start = 1'b0;
    cfg_we = 1'b0;
    cfg_idx = '0;
    cfg_x = '0;
    cfg_y = '0;
    cfg_scale = '0;
    cfg_id = '0;
    cfg_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rend_rst", 32'(rend_rst), 1);
    check("rst_enable", 32'(rend_enable), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(frame_done), 0);
    check("rst_overrun", 32'(overrun), 0);
    check("rst_idx", 32'(cur_idx), 0);
    check("rst_base", 32'(rend_base), 0);
    check("rst_sx", 32'(rend_sx), 0);
    rst_n = 1'b1;
    tick();

    start_frame();
    check("empty_commit_busy", 32'(busy), 1);
    check("empty_commit_rr", 32'(rend_rst), 1);
    empty_pass("empty");

    cfg_write(3, 100, 50, 8'h10, 2, 1);
    push(100, 50, 8'h10, 2);
    start_frame();
    repeat (4) tick();
    check("single_scan_idx", 32'(cur_idx), 3);
    check("single_scan_rr", 32'(rend_rst), 1);
    check("single_scan_en", 32'(rend_enable), 0);
    tick();
    check("single_run_en", 32'(rend_enable), 1);
    check("single_run_rr", 32'(rend_rst), 0);
    check("single_run_base", 32'(rend_base), 512);
    begin
      int n = 0;
      while (!rend_finished && n < 100) begin
        tick();
        n++;
      end
      check("single_fin_seen", 32'(rend_finished), 1);
      check("single_run_len", 32'(n), 20);
    end
    check("single_hold_sx", 32'(rend_sx), 100);
    tick();
    check("single_fin_en", 32'(rend_enable), 0);
    check("single_fin_rr", 32'(rend_rst), 1);
    check("single_next_idx", 32'(cur_idx), 4);
    for (int i = 1; i <= 12; i++) begin
      tick();
      check("single_done", 32'(frame_done), 32'(i == 12));
    end
    tick();

    do_reset();
    cfg_write(0, 7, 7, 0, 1, 1);
    start_frame();
    empty_pass("scale0");

    lat = 10;
    cfg_write(1, 200, 10, 1, 5, 1);
    push(200, 10, 1, 5);
    start_frame();
    repeat (3) tick();
    check("iso_run_en", 32'(rend_enable), 1);
    check("iso_run_idx", 32'(cur_idx), 1);
    cfg_write(1, 300, 20, 2, 6, 1);
    check("iso_sx_held", 32'(rend_sx), 200);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("ovr_pulse", 32'(overrun), 1);
    check("ovr_busy", 32'(busy), 1);
    tick();
    check("ovr_clear", 32'(overrun), 0);
    check("ovr_sx", 32'(rend_sx), 200);
    check("ovr_en", 32'(rend_enable), 1);
    wait_done();
    tick();

    push(300, 20, 2, 6);
    start_frame();
    wait_run();
    check("iso_next_sx", 32'(rend_sx), 300);
    wait_done();
    tick();

    push(300, 20, 2, 6);
    start_frame();
    wait_run();
    tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_en", 32'(rend_enable), 0);
    check("mid_rst_rr", 32'(rend_rst), 1);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_idx", 32'(cur_idx), 0);
    check("mid_rst_sx", 32'(rend_sx), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    start_frame();
    empty_pass("post_rst");

    check("sb_empty", 32'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
